// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative radix-2 HI/LO multiply/divide unit
module alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               qneg;
  logic               rneg;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     msum;
  logic [WIDTH+1:0]   dsh;
  logic [WIDTH+1:0]   ddiff;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;

  always_comb begin
    a_abs = (op[1] && a[WIDTH-1]) ? -a : a;
    b_abs = (op[1] && b[WIDTH-1]) ? -b : b;
  end

  // acc holds {partial, multiplier} for MUL and {remainder, dividend} for DIV
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    dsh      = acc[2*WIDTH:WIDTH-1];
    ddiff    = dsh - {2'b00, m};
    acc_step = '0;
    if (!is_div)
      acc_step = {1'b0, msum, acc[WIDTH-1:1]};
    else if (!ddiff[WIDTH+1])
      acc_step = {ddiff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {dsh[WIDTH:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod = qneg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quot = qneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_n = prod[2*WIDTH-1:WIDTH];
    lo_n = prod[WIDTH-1:0];
    if (is_div) begin
      if (m == '0) begin
        hi_n = a_raw;
        lo_n = '1;
      end else begin
        hi_n = rem;
        lo_n = quot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[0];
            qneg   <= op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg   <= op[1] & a[WIDTH-1];
            a_raw  <= a;
            m      <= op[0] ? b_abs : a_abs;
            acc    <= {{(WIDTH+1){1'b0}}, (op[0] ? a_abs : b_abs)};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WIDTH-1))
            state <= FIX;
        end
        FIX: begin
          hi    <= hi_n;
          lo    <= lo_n;
          div0  <= is_div && (m == '0);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv with arithmetic reference model
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic        div0;
  logic [15:0] hi;
  logic [15:0] lo;

  alu_muldiv #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  int run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: plain integer arithmetic, C-style truncating signed division
  task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] ehi, output logic [15:0] elo, output logic ed0);
    logic [31:0] p;
    int sx, sy, q, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ed0 = 1'b0;
    case (o)
      2'b00: p = {16'h0, x} * {16'h0, y};
      2'b10: p = sx * sy;
      2'b01: begin
        if (y == 0) begin p = {x, 16'hFFFF}; ed0 = 1'b1; end
        else p = {16'(x % y), 16'(x / y)};
      end
      default: begin
        if (y == 0) begin p = {x, 16'hFFFF}; ed0 = 1'b1; end
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[15:0], q[15:0]};
        end
      end
    endcase
    ehi = p[31:16];
    elo = p[15:0];
  endtask

  // Called in the phase just after a rising edge
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ehi, input logic [15:0] elo, input logic ed0,
                        input bit push, output int c0);
    int n;
    exp_t e;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("idle_wait", 32'd1, 32'd0);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    c0 = cyc;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.div0 = ed0; e.cyc = c0 + 17;
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) run_len = 0;
    else begin
      if (busy) run_len++;
      else if (run_len != 0) begin
        check("busy_len", run_len, 18);
        run_len = 0;
      end
      if (done) begin
        if (sbq.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          check("done_cyc", cyc, e.cyc);
          check("hi", {16'h0, hi}, {16'h0, e.hi});
          check("lo", {16'h0, lo}, {16'h0, e.lo});
          check("div0", {31'h0, div0}, {31'h0, e.div0});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, c1, n;
    logic [1:0]  o;
    logic [15:0] x, y, ehi, elo;
    logic        ed0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_hilo", {hi, lo}, 32'd0);
    check("rst_div0", {31'h0, div0}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 1'b1, c0);
    run_op(2'b10, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0, 1'b1, c0);
    run_op(2'b10, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 1'b1, c0);
    run_op(2'b01, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 1'b1, c0);
    run_op(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 1'b1, c0);
    run_op(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b1, c0);
    run_op(2'b01, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b1, c0);
    run_op(2'b00, 16'd2,    16'd3,    16'h0000, 16'h0006, 1'b0, 1'b1, c0);

    // starts while busy and in the DONE cycle must be ignored
    run_op(2'b00, 16'h1234, 16'h0056, 16'h0006, 16'h1D78, 1'b0, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    op = 2'b01; a = 16'h0009; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (cyc < c0 + 17 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_phase", {31'h0, done}, 32'd1);
    op = 2'b11; a = 16'h7777; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", {31'h0, busy}, 32'd0);
    run_op(2'b01, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 1'b1, c1);
    check("back_to_back", c1, c0 + 19);

    // asynchronous reset in the middle of CALC
    run_op(2'b00, 16'hABCD, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, c0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_hilo", {hi, lo}, 32'd0);
    check("midrst_div0", {31'h0, div0}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    run_op(2'b10, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0, 1'b1, c0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if (i % 10 == 0) x = 16'h8000;
      if (i % 10 == 1) y = 16'hFFFF;
      if (i % 10 == 2) y = 16'h0001;
      model(o, x, y, ehi, elo, ed0);
      run_op(o, x, y, ehi, elo, ed0, 1'b1, c0);
    end

    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_empty", sbq.size(), 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
